// File: rtl/approx_seq_mul.sv
// approx_seq_mul: sequential shift-add unsigned multiplier, one multiplier bit per cycle.
// Approximate mode discards partial products in columns below DROP_COLS and clears the
// low TRUNC_BITS bits of the product. Operands and results use valid/ready handshakes.
module approx_seq_mul #(
    parameter int unsigned WIDTH      = 6,
    parameter int unsigned DROP_COLS  = 5,
    parameter int unsigned TRUNC_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 approx_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic                 busy
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;      // shifted right each step, b_q[0] is multiplier bit k
    logic               mode_q;
    logic [CW-1:0]      k;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   a_masked;
    logic [2*WIDTH-1:0] pp;
    logic [2*WIDTH-1:0] res;

    // Partial product for step k: multiplicand bits in dropped columns are masked off
    always_comb begin
        a_masked = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            a_masked[i] = a_q[i] & (~mode_q | ((i + 32'(k)) >= DROP_COLS));
        end
        pp = '0;
        if (b_q[0]) begin
            pp = {{WIDTH{1'b0}}, a_masked} << k;
        end
    end

    // Final product: low bits cleared in approximate mode
    always_comb begin
        res = acc;
        for (int unsigned j = 0; j < 2 * WIDTH; j++) begin
            if (mode_q && (j < TRUNC_BITS)) begin
                res[j] = 1'b0;
            end
        end
    end

    // Control FSM and datapath; the extra RUN cycle at k==WIDTH registers the result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= 1'b0;
            k      <= '0;
            acc    <= '0;
            out_p  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q    <= in_a;
                        b_q    <= in_b;
                        mode_q <= approx_en;
                        acc    <= '0;
                        k      <= '0;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (k == CW'(WIDTH)) begin
                        out_p <= res;
                        state <= S_DONE;
                    end else begin
                        acc <= acc + pp;
                        b_q <= b_q >> 1;
                        k   <= k + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_approx_seq_mul.sv
// Self-checking bench for approx_seq_mul (WIDTH=6, DROP_COLS=5, TRUNC_BITS=4).
module tb_approx_seq_mul;

    localparam int unsigned W = 6;
    localparam int unsigned D = 5;
    localparam int unsigned T = 4;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    in_a;
    logic [W-1:0]    in_b;
    logic            approx_en;
    logic            out_valid;
    logic            out_ready;
    logic [2*W-1:0]  out_p;
    logic            busy;

    int checks = 0;
    int errors = 0;

    approx_seq_mul #(
        .WIDTH(W),
        .DROP_COLS(D),
        .TRUNC_BITS(T)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_b(in_b),
        .approx_en(approx_en),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_p(out_p),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: sum of kept partial-product bits, then clear low bits in approx mode
    function automatic logic [2*W-1:0] golden(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic m);
        int unsigned s;
        s = 0;
        for (int i = 0; i < W; i++)
            for (int j = 0; j < W; j++)
                if (a[i] && b[j] && (!m || (i + j) >= D))
                    s += (1 << (i + j));
        if (m) s = s & ~((1 << T) - 1);
        return s[2*W-1:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer operands, scramble inputs after accept, wait for out_valid (out_ready held low)
    task automatic start_wait(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                              output logic [2*W-1:0] p, output int lat);
        chk("in_ready_before_accept", in_ready, 1);
        in_a = a; in_b = b; approx_en = m; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        in_a = W'($urandom); in_b = W'($urandom); approx_en = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        p = out_p;
    endtask

    // Consume the result; while stalled, output must stay frozen
    task automatic drain(input bit rnd, input logic [2*W-1:0] p);
        logic hs;
        int n;
        hs = 1'b0;
        n = 0;
        while (!hs && n < 100) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            hs = out_ready;
            tick();
            n++;
            if (!hs) begin
                chk("stall_out_p", out_p, p);
                chk("stall_out_valid", out_valid, 1);
            end
        end
        chk("drain_handshake", hs, 1);
        out_ready = 1'b0;
        chk("after_hs_idle", in_ready, 1);
    endtask

    initial begin
        logic [2*W-1:0] p;
        logic [W-1:0]   ra, rb;
        logic           rm;
        int lat;
        bit seen;

        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; approx_en = 1'b0; out_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // 1. reset state
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_p", out_p, 0);
        chk("rst_busy", busy, 0);

        // 2./3. directed products
        start_wait(6'd63, 6'd63, 1'b0, p, lat);
        chk("63x63_exact", p, 3969);
        chk("63x63_exact_lat", lat, W + 1);
        chk("busy_done", busy, 1);
        drain(0, p);
        start_wait(6'd63, 6'd63, 1'b1, p, lat);
        chk("63x63_approx", p, 3840);
        drain(0, p);
        start_wait(6'd3, 6'd5, 1'b1, p, lat);
        chk("3x5_approx", p, 0);
        drain(0, p);
        start_wait(6'd3, 6'd5, 1'b0, p, lat);
        chk("3x5_exact", p, 15);
        drain(0, p);
        start_wait(6'd32, 6'd1, 1'b1, p, lat);
        chk("32x1_approx", p, 32);
        drain(0, p);
        chk("last_result_held", out_p, 32);

        // 4. backpressure for 10 cycles with a competing operand offer
        start_wait(6'd45, 6'd27, 1'b0, p, lat);
        chk("bp_result", p, 1215);
        in_valid = 1'b1; in_a = 6'd7; in_b = 6'd9; approx_en = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("bp_out_p", out_p, 1215);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_ready", in_ready, 1);
        chk("bp_release_busy", busy, 0);
        tick(); tick();
        chk("bp_no_accept", busy, 0);

        // 5. reset in the middle of a run
        in_a = 6'd50; in_b = 6'd61; approx_en = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        chk("midrun_busy", busy, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrun_rst_ready", in_ready, 1);
        chk("midrun_rst_busy", busy, 0);
        chk("midrun_rst_out_p", out_p, 0);
        seen = 0;
        out_ready = 1'b1;
        for (int c = 0; c < W + 4; c++) begin
            if (out_valid) seen = 1;
            tick();
        end
        out_ready = 1'b0;
        chk("midrun_no_output", seen, 0);
        start_wait(6'd50, 6'd61, 1'b1, p, lat);
        chk("after_rst_op", p, golden(6'd50, 6'd61, 1'b1));
        drain(0, p);

        // 6. random operations against the reference model
        for (int n = 0; n < 1000; n++) begin
            ra = W'($urandom); rb = W'($urandom); rm = 1'($urandom);
            start_wait(ra, rb, rm, p, lat);
            chk("rand_p", p, golden(ra, rb, rm));
            chk("rand_lat", lat, W + 1);
            drain(1, p);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
